single_cycle_proc: RTL and testbench

- Single-cycle RV32I-subset processor core: fetch, decode, execute, memory access and writeback all complete in one clock.
- Instruction memory and data memory sit outside the block. The core presents the PC and data-memory address/data/write-enable, and consumes the instruction word and load data combinationally.
- Top-level datapath of the SoC, instantiated beside the imem/dmem models.

---
 rtl/single_cycle_proc.sv | 233 +++++++++++++++++++++++
 tb/tb_single_cycle_proc.sv | 127 ++++++++++++
 2 files changed

// File: rtl/single_cycle_proc.sv
// Single-cycle RV32I-subset core: fetch, decode, execute, memory and writeback all complete in one clock.
// Define SCP_UPPER_IMM_EN to add lui/auipc; otherwise both opcodes decode as NOP.
module single_cycle_proc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic        MemWrite,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_t;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];
  assign rd     = Instr[11:7];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];

  assign imm_i = {{20{Instr[31]}}, Instr[31:20]};
  assign imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign imm_b = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign imm_j = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
  assign imm_u = {Instr[31:12], 12'b0};

  // Register file: entry 0 is held at zero and also masked on read.
  logic [31:0] rf [32];
  logic [31:0] rd1, rd2;

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Decode
  logic        reg_write;
  logic        mem_write;
  logic        is_beq, is_bne, is_jal;
  logic        use_imm;
  logic [31:0] imm_sel;
  alu_op_t     alu_op;
  srca_t       srca_sel;
  wb_t         wb_sel;

  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jal    = 1'b0;
    use_imm   = 1'b0;
    imm_sel   = imm_i;
    alu_op    = ALU_ADD;
    srca_sel  = SRCA_RS1;
    wb_sel    = WB_ALU;
    unique case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 ||
            (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          reg_write = 1'b1;
          case (funct3)
            3'b000:  alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
          endcase
        end
      end
      OP_I: begin
        use_imm = 1'b1;
        case (funct3)
          3'b000: begin alu_op = ALU_ADD;  reg_write = 1'b1; end
          3'b010: begin alu_op = ALU_SLT;  reg_write = 1'b1; end
          3'b011: begin alu_op = ALU_SLTU; reg_write = 1'b1; end
          3'b100: begin alu_op = ALU_XOR;  reg_write = 1'b1; end
          3'b110: begin alu_op = ALU_OR;   reg_write = 1'b1; end
          3'b111: begin alu_op = ALU_AND;  reg_write = 1'b1; end
          3'b001: begin
            alu_op    = ALU_SLL;
            reg_write = (funct7 == 7'b0000000);
          end
          default: begin
            // Only srai carries bit 30; any other upper-field value is illegal.
            alu_op    = funct7[5] ? ALU_SRA : ALU_SRL;
            reg_write = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        use_imm = 1'b1;
        if (funct3 == 3'b010) begin
          reg_write = 1'b1;
          wb_sel    = WB_MEM;
        end
      end
      OP_STORE: begin
        use_imm = 1'b1;
        imm_sel = imm_s;
        mem_write = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        alu_op = ALU_SUB;
        is_beq = (funct3 == 3'b000);
        is_bne = (funct3 == 3'b001);
      end
      OP_JAL: begin
        is_jal    = 1'b1;
        reg_write = 1'b1;
        srca_sel  = SRCA_PC;
        use_imm   = 1'b1;
        imm_sel   = 32'd4;
        wb_sel    = WB_PC4;
      end
`ifdef SCP_UPPER_IMM_EN
      OP_LUI: begin
        reg_write = 1'b1;
        srca_sel  = SRCA_ZERO;
        use_imm   = 1'b1;
        imm_sel   = imm_u;
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        srca_sel  = SRCA_PC;
        use_imm   = 1'b1;
        imm_sel   = imm_u;
      end
`else
      OP_LUI, OP_AUIPC: begin
        reg_write = 1'b0;
      end
`endif
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // ALU
  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt;
  logic        zero;

  always_comb begin
    alu_a = rd1;
    case (srca_sel)
      SRCA_PC:   alu_a = PC;
      SRCA_ZERO: alu_a = 32'd0;
      default:   alu_a = rd1;
    endcase
  end

  assign alu_b = use_imm ? imm_sel : rd2;
  assign shamt = alu_b[4:0];

  always_comb begin
    ALUResult = 32'd0;
    case (alu_op)
      ALU_ADD:  ALUResult = alu_a + alu_b;
      ALU_SUB:  ALUResult = alu_a - alu_b;
      ALU_SLL:  ALUResult = alu_a << shamt;
      ALU_SLT:  ALUResult = {31'd0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: ALUResult = {31'd0, alu_a < alu_b};
      ALU_XOR:  ALUResult = alu_a ^ alu_b;
      ALU_SRL:  ALUResult = alu_a >> shamt;
      ALU_SRA:  ALUResult = $unsigned($signed(alu_a) >>> shamt);
      ALU_OR:   ALUResult = alu_a | alu_b;
      ALU_AND:  ALUResult = alu_a & alu_b;
      default:  ALUResult = 32'd0;
    endcase
  end

  assign zero = (ALUResult == 32'd0);

  // Next PC: the branch/jump target needs its own adder because the ALU carries PC+4 for jal.
  logic [31:0] pc_plus4, pc_target, pc_next, wb_data;
  logic        take_target;

  assign pc_plus4    = PC + 32'd4;
  assign pc_target   = PC + (is_jal ? imm_j : imm_b);
  assign take_target = is_jal | (is_beq & zero) | (is_bne & ~zero);
  assign pc_next     = take_target ? pc_target : pc_plus4;

  always_comb begin
    wb_data = ALUResult;
    case (wb_sel)
      WB_MEM:  wb_data = ReadData;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = ALUResult;
    endcase
  end

  assign MemWrite  = mem_write & reset;
  assign WriteData = rd2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      PC <= RESET_PC;
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else begin
      PC <= pc_next;
      if (reg_write && rd != 5'd0) rf[rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_single_cycle_proc.sv
// Directed-vector bench for single_cycle_proc: the driver pushes expected outputs per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_single_cycle_proc;

  localparam int W = 101;
  localparam logic [3:0] M_PC = 4'b1000, M_ALU = 4'b0100, M_WD = 4'b0010, M_MW = 4'b0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, Instr, ALUResult, WriteData, ReadData;
  logic        MemWrite;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           bad = 0;

  single_cycle_proc #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [3:0] mask, input logic [31:0] pc, input logic [31:0] alu,
                          input logic [31:0] wd, input logic mw, input string name);
    exp_q.push_back({mask, pc, alu, wd, mw});
    name_q.push_back(name);
  endtask

  // One instruction per cycle: applied just after the rising edge, checked at the falling edge.
  task automatic step(input logic [31:0] instr, input logic [31:0] rdata, input logic [3:0] mask,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] wd,
                      input logic mw, input string name);
    @(posedge clk);
    #1;
    Instr    = instr;
    ReadData = rdata;
    push_exp(mask, pc, alu, wd, mw, name);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (e[100]) begin
        total++;
        if (PC !== e[96:65]) begin bad++; $display("FAIL %s pc: got %h want %h", n, PC, e[96:65]); end
      end
      if (e[99]) begin
        total++;
        if (ALUResult !== e[64:33]) begin bad++; $display("FAIL %s alu: got %h want %h", n, ALUResult, e[64:33]); end
      end
      if (e[98]) begin
        total++;
        if (WriteData !== e[32:1]) begin bad++; $display("FAIL %s wdata: got %h want %h", n, WriteData, e[32:1]); end
      end
      if (e[97]) begin
        total++;
        if (MemWrite !== e[0]) begin bad++; $display("FAIL %s memwrite: got %b want %b", n, MemWrite, e[0]); end
      end
    end
  end

  initial begin
    reset = 1'b1; Instr = 32'h0000_0033; ReadData = 32'd0;
    #1 reset = 1'b0;
    // In reset: PC held, sw must not write memory.
    step(32'h0010_2423, 0, M_PC | M_MW,         32'h00, 0, 0, 1'b0, "rst_sw");
    step(32'h0000_0033, 0, M_PC | M_ALU | M_MW, 32'h00, 0, 0, 1'b0, "rst_nop");
    #5 reset = 1'b1;
    step(32'h0000_0033, 0, M_PC | M_ALU | M_MW, 32'h04, 0, 0, 1'b0, "nop_pc4");
    step(32'h0050_0093, 0, M_PC | M_ALU | M_MW, 32'h08, 5, 0, 1'b0, "addi");
    step(32'h0010_2423, 0, '1,                  32'h0C, 8, 5, 1'b1, "sw");
    step(32'h0000_0463, 0, M_PC | M_ALU | M_MW, 32'h10, 0, 0, 1'b0, "beq");
    step(32'h0080_2103, 32'h1234_5678, M_PC | M_ALU | M_MW, 32'h18, 8, 0, 1'b0, "lw");
    step(32'h0001_01B3, 0, M_PC | M_ALU | M_MW, 32'h1C, 32'h1234_5678, 0, 1'b0, "add");
    step(32'h0100_00EF, 0, '1,                  32'h20, 32'h24, 0, 1'b0, "jal");
    step(32'h0000_1463, 0, M_PC | M_ALU | M_MW, 32'h30, 0, 0, 1'b0, "bne_eq");
    step(32'h0000_0013, 0, M_PC | M_ALU | M_MW, 32'h34, 0, 0, 1'b0, "nop_addi");
    step(32'h0000_8033, 0, M_PC | M_ALU,        32'h38, 32'h24, 0, 1'b0, "rd_x1");
    step(32'h0001_0033, 0, M_PC | M_ALU,        32'h3C, 32'h1234_5678, 0, 1'b0, "rd_x2");
    step(32'h0001_8033, 0, M_PC | M_ALU,        32'h40, 32'h1234_5678, 0, 1'b0, "rd_x3");
    step(32'h4010_0233, 0, M_PC | M_ALU,        32'h44, 32'hFFFF_FFDC, 0, 1'b0, "sub");
    step(32'h0002_22B3, 0, M_PC | M_ALU,        32'h48, 32'h1, 0, 1'b0, "slt");
    step(32'h0012_3033, 0, M_PC | M_ALU,        32'h4C, 32'h0, 0, 1'b0, "sltu");
    step(32'h4022_5013, 0, M_PC | M_ALU,        32'h50, 32'hFFFF_FFF7, 0, 1'b0, "srai");
    step(32'h0022_5013, 0, M_PC | M_ALU,        32'h54, 32'h3FFF_FFF7, 0, 1'b0, "srli");
    step(32'h0000_0303, 0, M_PC | M_MW,         32'h58, 0, 0, 1'b0, "lb_nop");
    step(32'h0010_0023, 0, M_PC | M_WD | M_MW,  32'h5C, 0, 32'h24, 1'b0, "sb_nop");
    step(32'h0003_0033, 0, M_PC | M_ALU,        32'h60, 32'h0, 0, 1'b0, "rd_x6");
    step(32'h0002_8033, 0, M_PC | M_ALU,        32'h64, 32'h1, 0, 1'b0, "rd_x5");

    // Asynchronous reset mid-cycle with a store on the bus.
    @(posedge clk);
    #1 Instr = 32'h0010_2423;
    #2 reset = 1'b0;
    push_exp(M_PC | M_MW, 32'h0, 0, 0, 1'b0, "mid_rst");
    step(32'h0000_0033, 0, M_PC | M_MW, 32'h0, 0, 0, 1'b0, "mid_rst_hold");
    #6 reset = 1'b1;
    step(32'h0000_8033, 0, M_PC | M_ALU, 32'h04, 0, 0, 1'b0, "clr_x1");
    step(32'h0001_0033, 0, M_PC | M_ALU, 32'h08, 0, 0, 1'b0, "clr_x2");
    step(32'h0002_0033, 0, M_PC | M_ALU, 32'h0C, 0, 0, 1'b0, "clr_x4");
`ifdef SCP_UPPER_IMM_EN
    step(32'h1234_50B7, 0, M_PC | M_ALU | M_MW, 32'h10, 32'h1234_5000, 0, 1'b0, "lui");
    step(32'h0000_8033, 0, M_PC | M_ALU,        32'h14, 32'h1234_5000, 0, 1'b0, "lui_x1");
    step(32'h0000_1417, 0, M_PC | M_ALU | M_MW, 32'h18, 32'h0000_1018, 0, 1'b0, "auipc");
`else
    step(32'h1234_50B7, 0, M_PC | M_MW,         32'h10, 0, 0, 1'b0, "lui_nop");
    step(32'h0000_8033, 0, M_PC | M_ALU,        32'h14, 32'h0, 0, 1'b0, "lui_x1");
    step(32'h0000_1417, 0, M_PC | M_MW,         32'h18, 0, 0, 1'b0, "auipc_nop");
`endif
    step(32'h0000_0033, 0, M_PC, 32'h1C, 0, 0, 1'b0, "final_pc");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
